// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a one-deep holding buffer so that
// back-to-back words stream without an idle bit between frames.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             data_valid_i,
  output logic             data_ready_o,
  input  logic             shift_i,
  output logic             serial_out_o,
  output logic             serial_valid_o,
  output logic             frame_start_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [WIDTH-1:0] shift_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic             done_q;
  // Low while in reset and for nothing else; keeps data_ready free of any
  // combinational path from the reset input.
  logic             rdy_q;

  logic             accept;
  logic             consume;
  logic             last_bit;
  logic             xfer;
  logic [WIDTH-1:0] shifted;

  // Handshake and strobe decode from registered state.
  always_comb begin
    accept   = data_valid_i && data_ready_o;
    consume  = (state_q == StShift) && shift_i;
    last_bit = consume && (bit_cnt_q == LastCnt);
    // hold_full_q excludes accept, so accept and xfer never coincide.
    xfer     = hold_full_q && ((state_q == StIdle) || last_bit);
    shifted  = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
  end

  // Buffer, shifter and FSM state, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      done_q      <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      rdy_q  <= 1'b1;
      done_q <= last_bit;

      if (accept) begin
        hold_q      <= data_in_i;
        hold_full_q <= 1'b1;
      end

      if (xfer) begin
        shift_q     <= hold_q;
        hold_full_q <= 1'b0;
        bit_cnt_q   <= '0;
        state_q     <= StShift;
      end else if (last_bit) begin
        // Nothing queued: drop back to idle with a quiet line.
        shift_q   <= '0;
        bit_cnt_q <= '0;
        state_q   <= StIdle;
      end else if (consume) begin
        shift_q   <= shifted;
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    data_ready_o   = rdy_q && !hold_full_q;
    serial_out_o   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    serial_valid_o = (state_q == StShift);
    frame_start_o  = (state_q == StShift) && (bit_cnt_q == '0);
    busy_o         = (state_q == StShift) || hold_full_q;
    done_o         = done_q;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share the
// same stimulus; a scoreboard queue holds the expected bit of each stream.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       shift = 1'b1;

  logic rdm, som, svm, fsm, bym, dnm;
  logic rdl, sol, svl, fsl, byl, dnl;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned consumed = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cnt_l = 0;
  int unsigned done_exp = 0;
  int unsigned done_cyc[$];

  logic shift_on = 1'b1;
  logic sparse = 1'b0;

  typedef struct {
    logic bm;
    logic bl;
    logic fs;
  } exp_t;
  exp_t sb_q[$];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk            (clk),
    .reset          (reset),
    .data_in_i      (data_in),
    .data_valid_i   (data_valid),
    .data_ready_o   (rdm),
    .shift_i        (shift),
    .serial_out_o   (som),
    .serial_valid_o (svm),
    .frame_start_o  (fsm),
    .busy_o         (bym),
    .done_o         (dnm)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk            (clk),
    .reset          (reset),
    .data_in_i      (data_in),
    .data_valid_i   (data_valid),
    .data_ready_o   (rdl),
    .shift_i        (shift),
    .serial_out_o   (sol),
    .serial_valid_o (svl),
    .frame_start_o  (fsl),
    .busy_o         (byl),
    .done_o         (dnl)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe generator: constant or one pulse every 4th cycle.
  always @(posedge clk) begin
    #1;
    shift = sparse ? ((cyc % 4) == 0) : shift_on;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: compares each consumed bit and checks hold between strobes.
  logic prev_v = 1'b0, prev_shift = 1'b0, prev_so = 1'b0, prev_fs = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_shift) begin
        chk("hold_sv", 32'(svm), 32'd1);
        chk("hold_out", 32'(som), 32'(prev_so));
        chk("hold_fs", 32'(fsm), 32'(prev_fs));
      end
      if (svm && shift) begin
        consumed++;
        if (sb_q.size() == 0) begin
          chk("extra_bit", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("bit_msb", 32'(som), 32'(e.bm));
          chk("bit_lsb", 32'(sol), 32'(e.bl));
          chk("fs_msb", 32'(fsm), 32'(e.fs));
          chk("fs_lsb", 32'(fsl), 32'(e.fs));
          chk("sv_lsb", 32'(svl), 32'd1);
        end
      end
      if (dnm) begin
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      if (dnl) done_cnt_l++;
      prev_v     = svm;
      prev_shift = shift;
      prev_so    = som;
      prev_fs    = fsm;
    end
  end

  // Offer a word, wait for acceptance and queue its expected bits.
  task automatic send(input logic [7:0] w);
    int t;
    @(posedge clk);
    #1;
    data_valid = 1'b1;
    data_in    = w;
    t = 0;
    forever begin
      @(negedge clk);
      if (rdm) break;
      t++;
      if (t > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        data_valid = 1'b0;
        return;
      end
    end
    for (int i = 0; i < 8; i++) sb_q.push_back('{w[7-i], w[i], (i == 0)});
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    done_exp++;
    @(negedge clk);
    chk("rdy_low", 32'(rdm), 32'd0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || bym) && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("idle_timeout", 32'(t < 200), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int gaps;
    int t;
    int unsigned c0;

    // Reset with a valid word offered.
    data_valid = 1'b1;
    data_in    = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_out_m", 32'({som, svm, fsm, bym, dnm, rdm}), 32'd0);
    chk("rst_out_l", 32'({sol, svl, fsl, byl, dnl, rdl}), 32'd0);
    data_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(rdm), 32'd1);
    chk("rel_busy", 32'(bym), 32'd0);

    // Single word, constant strobe.
    send(8'h8C);
    wait_idle();
    chk("single_done", done_cnt, done_exp);
    chk("single_done_l", done_cnt_l, done_exp);
    chk("single_sv", 32'(svm), 32'd0);
    chk("single_busy", 32'(bym), 32'd0);

    // Back-to-back words must stream gaplessly.
    send(8'h3C);
    send(8'hF0);
    gaps = 0;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(negedge clk);
      #1;
      if (sb_q.size() != 0 && !svm) gaps++;
      t++;
    end
    chk("b2b_gaps", 32'(gaps), 32'd0);
    wait_idle();
    chk("b2b_done", done_cnt, done_exp);
    if (done_cyc.size() >= 2)
      chk("b2b_spacing", done_cyc[$] - done_cyc[$-1], 32'd8);
    else
      chk("b2b_spacing", 32'(done_cyc.size()), 32'd2);

    // Sparse strobe, then idle strobes must change nothing.
    sparse = 1'b1;
    send(8'hA5);
    wait_idle();
    chk("sparse_done", done_cnt, done_exp);
    repeat (12) @(negedge clk);
    chk("idle_state", 32'({som, svm, fsm, bym, dnm, rdm}), 32'h01);
    chk("idle_done", done_cnt, done_exp);
    sparse = 1'b0;

    // Reset mid-word with a word buffered.
    c0 = consumed;
    send(8'hFF);
    send(8'h00);
    t = 0;
    while (consumed - c0 < 3 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("mid_timeout", 32'(t < 50), 32'd1);
    chk("mid_busy", 32'(bym), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_m", 32'({som, svm, fsm, bym, dnm, rdm}), 32'd0);
    chk("mid_rst_l", 32'({sol, svl, fsl, byl, dnl, rdl}), 32'd0);
    sb_q.delete();
    done_exp -= 2;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_ready", 32'(rdm), 32'd1);
    send(8'h81);
    wait_idle();
    repeat (10) @(negedge clk);
    chk("mid_done", done_cnt, done_exp);
    chk("mid_done_l", done_cnt_l, done_exp);
    chk("mid_quiet", 32'({svm, bym}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
